hamming_tx_serializer: RTL and testbench

Transmit-side serializer for the self-correcting message path. Accepts one 16-bit Hamming codeword per handshake and emits it one bit per accepted cycle with a 4-bit bit-select address. The receive end routes each bit to the codeword position given by that address, through a 1-to-16 demultiplexer that uses the same bit order. Supports output backpressure and back-to-back codewords with no idle bubble.

---
 rtl/hamming_tx_serializer_if.sv | 49 ++++
 rtl/hamming_tx_serializer.sv | 90 +++++++++
 tb/tb_hamming_tx_serializer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_tx_serializer_if.sv
// Handshake and serial-output bundle for the Hamming codeword transmit serializer.
// The master side supplies codewords and accepts serial bits; the slave side is the serializer.
interface hamming_tx_serializer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned CW    = 8
);
    // Codeword input handshake
    logic [WIDTH-1:0] word_in;
    logic             in_valid;
    logic             in_ready;

    // Serial bit output handshake plus framing markers
    logic             dout;
    logic [AW-1:0]    addr;
    logic             dout_valid;
    logic             dout_ready;
    logic             sof;
    logic             eof;

    // Completed-frame counter
    logic [CW-1:0]    frames_sent;

    modport master (
        output word_in,
        output in_valid,
        output dout_ready,
        input  in_ready,
        input  dout,
        input  addr,
        input  dout_valid,
        input  sof,
        input  eof,
        input  frames_sent
    );

    modport slave (
        input  word_in,
        input  in_valid,
        input  dout_ready,
        output in_ready,
        output dout,
        output addr,
        output dout_valid,
        output sof,
        output eof,
        output frames_sent
    );
endinterface

// File: rtl/hamming_tx_serializer.sv
// Serializes one codeword per input handshake, LSB first, tagging each bit with its
// position so the receiver demux can route it. One held word, no extra buffering;
// a new word may be loaded in the same cycle the last bit of the current one is taken.
module hamming_tx_serializer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned CW    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hamming_tx_serializer_if.slave  bus
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    frames_q;

    logic             last_bit_c;
    logic             bit_hs_c;
    logic             in_ready_c;
    logic             in_hs_c;

    // Handshake decode; in_ready opens on the last accepted bit so frames run back to back
    always_comb begin
        last_bit_c = (addr_q == LAST_ADDR);
        bit_hs_c   = (state_q == ST_SEND) && bus.dout_ready;
        in_ready_c = (state_q == ST_IDLE) || (bit_hs_c && last_bit_c);
        in_hs_c    = bus.in_valid && in_ready_c;
    end

    // Frame FSM, bit shifter, address counter and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            shift_q  <= '0;
            frames_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_hs_c) begin
                        shift_q <= bus.word_in;
                        addr_q  <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bit_hs_c) begin
                        // Shifting out the last bit leaves zeros, so dout idles low
                        shift_q <= {1'b0, shift_q[WIDTH-1:1]};
                        if (last_bit_c) begin
                            frames_q <= frames_q + CW'(1);
                            addr_q   <= '0;
                            if (in_hs_c) begin
                                shift_q <= bus.word_in;
                                state_q <= ST_SEND;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    // Outputs: dout/addr/valid straight from registers, markers decoded from registered addr
    assign bus.dout        = shift_q[0];
    assign bus.addr        = addr_q;
    assign bus.dout_valid  = (state_q == ST_SEND);
    assign bus.sof         = (state_q == ST_SEND) && (addr_q == '0);
    assign bus.eof         = (state_q == ST_SEND) && last_bit_c;
    assign bus.frames_sent = frames_q;
    assign bus.in_ready    = in_ready_c;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Self-checking bench for hamming_tx_serializer: directed scenarios plus random
// traffic, all checked every cycle against a frame-level reference model.
module tb_hamming_tx_serializer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hamming_tx_serializer_if #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) bus ();

    hamming_tx_serializer #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one held word, index of the bit on the wire, completed frames
    bit          m_busy;
    logic [15:0] m_word;
    int          m_idx;
    int          m_done;

    // Observation helpers for directed scenarios
    logic [15:0] obs_bits;
    int          valid_cycles;
    int          run_len;
    int          max_run;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_word = '0;
        m_idx  = 0;
        m_done = 0;
    endtask

    task automatic obs_reset();
        obs_bits     = '0;
        valid_cycles = 0;
        run_len      = 0;
        max_run      = 0;
    endtask

    // One clock cycle: apply inputs, compare at the falling edge, advance the model
    task automatic drive(input bit vin, input logic [15:0] w, input bit drdy, output bit accepted);
        bit exp_ready;
        bus.in_valid   = vin;
        bus.word_in    = w;
        bus.dout_ready = drdy;
        @(negedge clk);
        exp_ready = !m_busy || (m_idx == 15 && drdy);
        check_eq("dout_valid", 32'(bus.dout_valid), 32'(m_busy));
        check_eq("addr", 32'(bus.addr), m_busy ? 32'(m_idx) : 32'd0);
        if (m_busy) check_eq("dout", 32'(bus.dout), 32'(m_word[m_idx]));
        check_eq("sof", 32'(bus.sof), 32'(m_busy && m_idx == 0));
        check_eq("eof", 32'(bus.eof), 32'(m_busy && m_idx == 15));
        check_eq("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check_eq("frames_sent", 32'(bus.frames_sent), 32'(m_done % (1 << CW)));
        if (bus.dout_valid) begin
            valid_cycles++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (drdy) obs_bits[bus.addr] = bus.dout;
        end else begin
            run_len = 0;
        end
        accepted = vin && exp_ready;
        if (m_busy && drdy) begin
            if (m_idx == 15) begin
                m_done++;
                m_busy = 1'b0;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
        end
        if (accepted) begin
            m_word = w;
            m_idx  = 0;
            m_busy = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) drive(1'b1, w, 1'b1, acc);
        if (!acc) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input int n, input bit drdy);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, drdy, acc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        bit seen255;
        int f0;

        bus.in_valid   = 1'b0;
        bus.word_in    = '0;
        bus.dout_ready = 1'b0;
        rst_n          = 1'b0;
        model_reset();
        obs_reset();
        #1;
        check_eq("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        check_eq("rst_addr", 32'(bus.addr), 32'd0);
        check_eq("rst_dout", 32'(bus.dout), 32'd0);
        check_eq("rst_sof", 32'(bus.sof), 32'd0);
        check_eq("rst_eof", 32'(bus.eof), 32'd0);
        check_eq("rst_frames", 32'(bus.frames_sent), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Single frame, LSB-first sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
        obs_reset();
        send_word(16'hA5C3);
        run(16, 1'b1);
        check_eq("a5c3_bits", 32'(obs_bits), 32'h0000_A5C3);
        check_eq("a5c3_len", 32'(valid_cycles), 32'd16);
        check_eq("a5c3_frames", 32'(bus.frames_sent), 32'd1);
        run(2, 1'b1);

        // Backpressure: 3 stalls at addr 0, 2 stalls at addr 15
        obs_reset();
        send_word(16'h0001);
        run(3, 1'b0);
        run(15, 1'b1);
        run(2, 1'b0);
        run(1, 1'b1);
        check_eq("bp_len", 32'(valid_cycles), 32'd21);
        check_eq("bp_bits", 32'(obs_bits), 32'h0000_0001);

        // Back-to-back FFFF then 0000 with in_valid held
        obs_reset();
        f0 = m_done;
        send_word(16'hFFFF);
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) drive(1'b1, 16'h0000, 1'b1, acc);
        if (!acc) check_eq("b2b_accept_timeout", 32'd0, 32'd1);
        run(20, 1'b1);
        check_eq("b2b_valid", 32'(valid_cycles), 32'd32);
        check_eq("b2b_run", 32'(max_run), 32'd32);
        check_eq("b2b_frames", 32'(bus.frames_sent), 32'((f0 + 2) % (1 << CW)));

        // Ignored input mid-frame
        obs_reset();
        send_word(16'h8000);
        run(5, 1'b1);
        drive(1'b1, 16'h1234, 1'b1, acc);
        check_eq("ign_accept", 32'(acc), 32'd0);
        run(20, 1'b1);
        check_eq("ign_bits", 32'(obs_bits), 32'h0000_8000);
        check_eq("ign_len", 32'(valid_cycles), 32'd16);

        // Reset mid-frame at addr 7
        send_word(16'hF0F0);
        run(7, 1'b1);
        check_eq("pre_rst_addr", 32'(bus.addr), 32'd7);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_dout_valid", 32'(bus.dout_valid), 32'd0);
        check_eq("midrst_addr", 32'(bus.addr), 32'd0);
        check_eq("midrst_dout", 32'(bus.dout), 32'd0);
        check_eq("midrst_sof", 32'(bus.sof), 32'd0);
        check_eq("midrst_eof", 32'(bus.eof), 32'd0);
        check_eq("midrst_frames", 32'(bus.frames_sent), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_reset();
        send_word(16'h00FF);
        run(17, 1'b1);
        check_eq("post_rst_bits", 32'(obs_bits), 32'h0000_00FF);
        check_eq("post_rst_frames", 32'(bus.frames_sent), 32'd1);

        // Random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0), acc);
        end
        run(40, 1'b1);

        // Counter wrap over 256 back-to-back frames
        do_reset();
        seen255 = 1'b0;
        for (int i = 0; i < 5000 && m_done < 256; i++) begin
            drive(1'b1, 16'($urandom), 1'b1, acc);
            if (m_done == 255 && !seen255) begin
                seen255 = 1'b1;
                check_eq("wrap_255", 32'(bus.frames_sent), 32'd255);
            end
        end
        check_eq("wrap_reached", 32'(m_done), 32'd256);
        check_eq("wrap_0", 32'(bus.frames_sent), 32'd0);
        run(20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
